alu_operand_loader: RTL and testbench

- Upstream sequencing stage for the Lab3 ALU datapath, including the and_N_bits unit.
- Captures operand A, operand B and an opcode from board switches, one button press per field.
- Presents the held operands to the ALU with a valid/ready handshake, then registers the ALU result for the display stage.
- Debounce is handled externally. This block only synchronises the buttons and detects their rising edges.

---
 rtl/alu_operand_loader.sv | 156 +++++++++++++++
 tb/tb_alu_operand_loader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_loader.sv
// Operand/opcode capture sequencer in front of the Lab3 ALU: buttons step through
// A, B and opcode loads, issue the operands with valid/ready and latch the result.
module alu_operand_loader #(
    parameter int N   = 4,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   sw_data,
    input  logic           btn_next,
    input  logic           btn_clear,
    input  logic           alu_ready,
    input  logic [N-1:0]   alu_result,
    output logic [N-1:0]   operand_a,
    output logic [N-1:0]   operand_b,
    output logic [OPW-1:0] opcode,
    output logic           alu_valid,
    output logic [N-1:0]   result,
    output logic           result_valid,
    output logic [2:0]     state_dbg
);

    // Handshake: alu_valid is high for every cycle spent in S_ISSUE; a transfer
    // happens on a rising edge where alu_valid and alu_ready are both high, and
    // alu_result is sampled on that same edge. Operands never change while valid.
    typedef enum logic [2:0] {
        S_A     = 3'd0,
        S_B     = 3'd1,
        S_OP    = 3'd2,
        S_ISSUE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Bit 0 is the next button, bit 1 the clear button.
    logic [1:0] btn_raw;
    logic [1:0] btn_meta_q;
    logic [1:0] btn_sync_q;
    logic [1:0] btn_prev_q;
    logic [1:0] btn_pulse_q;
    logic [1:0] btn_pulse_d;

    logic next_p;
    logic clear_p;

    state_t         state_q;
    logic [N-1:0]   operand_a_q;
    logic [N-1:0]   operand_b_q;
    logic [OPW-1:0] opcode_q;
    logic [N-1:0]   result_q;
    logic           alu_valid_q;
    logic           result_valid_q;

    logic [OPW-1:0] sw_opcode;
    logic           illegal_state;

    assign btn_raw     = {btn_clear, btn_next};
    assign btn_pulse_d = btn_sync_q & ~btn_prev_q;

    // Two-flop synchroniser, then a registered rising-edge detect: one-cycle
    // pulse on the third edge after the raw input rises, one pulse per press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta_q  <= 2'b00;
            btn_sync_q  <= 2'b00;
            btn_prev_q  <= 2'b00;
            btn_pulse_q <= 2'b00;
        end else begin
            btn_meta_q  <= btn_raw;
            btn_sync_q  <= btn_meta_q;
            btn_prev_q  <= btn_sync_q;
            btn_pulse_q <= btn_pulse_d;
        end
    end

    assign next_p  = btn_pulse_q[0];
    assign clear_p = btn_pulse_q[1];

    generate
        if (OPW > N) begin : g_op_zext
            assign sw_opcode = {{(OPW - N){1'b0}}, sw_data};
        end else begin : g_op_trunc
            assign sw_opcode = sw_data[OPW-1:0];
        end
    endgenerate

    assign illegal_state = (state_q > S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_A;
            operand_a_q    <= '0;
            operand_b_q    <= '0;
            opcode_q       <= '0;
            result_q       <= '0;
            alu_valid_q    <= 1'b0;
            result_valid_q <= 1'b0;
        end else if (clear_p || illegal_state) begin
            // Clear wins over next and abandons any pending handshake.
            state_q        <= S_A;
            operand_a_q    <= '0;
            operand_b_q    <= '0;
            opcode_q       <= '0;
            result_q       <= '0;
            alu_valid_q    <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_A: begin
                    if (next_p) begin
                        operand_a_q <= sw_data;
                        state_q     <= S_B;
                    end
                end
                S_B: begin
                    if (next_p) begin
                        operand_b_q <= sw_data;
                        state_q     <= S_OP;
                    end
                end
                S_OP: begin
                    if (next_p) begin
                        opcode_q    <= sw_opcode;
                        alu_valid_q <= 1'b1;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (alu_ready) begin
                        result_q       <= alu_result;
                        result_valid_q <= 1'b1;
                        alu_valid_q    <= 1'b0;
                        state_q        <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (next_p) begin
                        result_valid_q <= 1'b0;
                        state_q        <= S_A;
                    end
                end
                default: begin
                    state_q <= S_A;
                end
            endcase
        end
    end

    assign operand_a    = operand_a_q;
    assign operand_b    = operand_b_q;
    assign opcode       = opcode_q;
    assign alu_valid    = alu_valid_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader: button-driven loads, handshake,
// backpressure, clear priority, reset and wrap-around.
module tb_alu_operand_loader;

  localparam int N   = 4;
  localparam int OPW = 4;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   sw_data;
  logic           btn_next;
  logic           btn_clear;
  logic           alu_ready;
  logic [N-1:0]   alu_result;
  logic [N-1:0]   operand_a;
  logic [N-1:0]   operand_b;
  logic [OPW-1:0] opcode;
  logic           alu_valid;
  logic [N-1:0]   result;
  logic           result_valid;
  logic [2:0]     state_dbg;

  int n_checks;
  int n_fail;

  alu_operand_loader #(.N(N), .OPW(OPW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw_data      (sw_data),
    .btn_next     (btn_next),
    .btn_clear    (btn_clear),
    .alu_ready    (alu_ready),
    .alu_result   (alu_result),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .opcode       (opcode),
    .alu_valid    (alu_valid),
    .result       (result),
    .result_valid (result_valid),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // simple ALU stand-in: opcode 0 is AND, anything else OR
  always_comb begin
    alu_result = (opcode == '0) ? (operand_a & operand_b) : (operand_a | operand_b);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Idle long enough for the previous press to drain, then press; returns on
  // the negedge right after the FSM has acted on the pulse.
  task automatic press(input logic nxt, input logic clr);
    btn_next  = 1'b0;
    btn_clear = 1'b0;
    repeat (3) @(negedge clk);
    btn_next  = nxt;
    btn_clear = clr;
    repeat (4) @(negedge clk);
    btn_next  = 1'b0;
    btn_clear = 1'b0;
  endtask

  // Load one field, then scramble the switches to prove only the load edge samples.
  task automatic load(input logic [N-1:0] val);
    sw_data = val;
    press(1'b1, 1'b0);
    sw_data = N'($urandom_range(0, (1 << N) - 1));
  endtask

  task automatic do_clear();
    press(1'b0, 1'b1);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    sw_data   = '0;
    btn_next  = 1'b0;
    btn_clear = 1'b0;
    alu_ready = 1'b0;

    // reset state
    #1;
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_opa", 32'(operand_a), 32'd0);
    check("rst_valid", 32'(alu_valid), 32'd0);
    check("rst_rvalid", 32'(result_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // reset mid-load
    load(4'b0101);
    check("mid_state_b", 32'(state_dbg), 32'd1);
    check("mid_opa", 32'(operand_a), 32'b0101);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_state", 32'(state_dbg), 32'd0);
    check("mid_rst_opa", 32'(operand_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    load(4'b0011);
    check("mid_reload_opa", 32'(operand_a), 32'b0011);
    check("mid_reload_state", 32'(state_dbg), 32'd1);
    check("mid_reload_opb", 32'(operand_b), 32'd0);
    do_clear();
    check("clr_state", 32'(state_dbg), 32'd0);

    // full sequence with ready tied high
    alu_ready = 1'b1;
    load(4'b0101);
    load(4'b1011);
    check("full_state_op", 32'(state_dbg), 32'd2);
    load(4'h0);
    check("full_issue_state", 32'(state_dbg), 32'd3);
    check("full_issue_valid", 32'(alu_valid), 32'd1);
    check("full_issue_rvalid", 32'(result_valid), 32'd0);
    check("full_opa", 32'(operand_a), 32'b0101);
    check("full_opb", 32'(operand_b), 32'b1011);
    @(negedge clk);
    check("full_done_state", 32'(state_dbg), 32'd4);
    check("full_done_valid", 32'(alu_valid), 32'd0);
    check("full_result", 32'(result), 32'b0001);
    check("full_rvalid", 32'(result_valid), 32'd1);
    repeat (3) @(negedge clk);
    check("full_hold_result", 32'(result), 32'b0001);
    check("full_hold_state", 32'(state_dbg), 32'd4);

    // backpressure
    do_clear();
    check("clr_result", 32'(result), 32'd0);
    alu_ready = 1'b0;
    load(4'b1101);
    load(4'b1011);
    load(4'h0);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp_valid_%0d", i), 32'(alu_valid), 32'd1);
      check($sformatf("bp_opa_%0d", i), 32'(operand_a), 32'b1101);
      check($sformatf("bp_opb_%0d", i), 32'(operand_b), 32'b1011);
      check($sformatf("bp_result_%0d", i), 32'(result), 32'd0);
      check($sformatf("bp_rvalid_%0d", i), 32'(result_valid), 32'd0);
      if (i < 9) @(negedge clk);
    end
    alu_ready = 1'b1;
    #1;
    check("bp_ready_valid", 32'(alu_valid), 32'd1);
    @(negedge clk);
    check("bp_done_state", 32'(state_dbg), 32'd4);
    check("bp_result", 32'(result), 32'b1001);
    check("bp_rvalid", 32'(result_valid), 32'd1);

    // button held 20 cycles gives one advance
    do_clear();
    alu_ready = 1'b0;
    sw_data   = 4'b0110;
    repeat (3) @(negedge clk);
    btn_next = 1'b1;
    repeat (20) @(negedge clk);
    btn_next = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_state", 32'(state_dbg), 32'd1);
    check("hold_opa", 32'(operand_a), 32'b0110);
    check("hold_opb", 32'(operand_b), 32'd0);

    // next ignored while issuing
    load(4'b0011);
    load(4'h9);
    check("ign_opcode", 32'(opcode), 32'h9);
    press(1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check("ign_state", 32'(state_dbg), 32'd3);
    check("ign_valid", 32'(alu_valid), 32'd1);
    check("ign_opb", 32'(operand_b), 32'b0011);
    do_clear();
    check("ign_clr_state", 32'(state_dbg), 32'd0);
    check("ign_clr_valid", 32'(alu_valid), 32'd0);
    check("ign_clr_opcode", 32'(opcode), 32'd0);

    // clear beats next in the same cycle
    load(4'b1111);
    check("prio_opa_loaded", 32'(operand_a), 32'b1111);
    sw_data = 4'b1010;
    press(1'b1, 1'b1);
    check("prio_state", 32'(state_dbg), 32'd0);
    check("prio_opa", 32'(operand_a), 32'd0);
    check("prio_opb", 32'(operand_b), 32'd0);

    // wrap-around from done
    alu_ready = 1'b1;
    load(4'b1111);
    load(4'b1111);
    load(4'h0);
    @(negedge clk);
    check("wrap_done_state", 32'(state_dbg), 32'd4);
    check("wrap_result", 32'(result), 32'b1111);
    press(1'b1, 1'b0);
    check("wrap_state", 32'(state_dbg), 32'd0);
    check("wrap_rvalid", 32'(result_valid), 32'd0);
    check("wrap_opa_kept", 32'(operand_a), 32'b1111);
    load(4'b0010);
    check("wrap_opa_new", 32'(operand_a), 32'b0010);
    check("wrap_state_b", 32'(state_dbg), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
